// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and constants for the AES-128 key-schedule blocks.
//   aes_block_t    : 128-bit state/key, indexed [row][col] -> byte.
//                    Word c is {b[0][c], b[1][c], b[2][c], b[3][c]}.
//   aes_word_t     : one 32-bit key-schedule word.
//   aes_kx_state_t : inverse key expander FSM states.
//   RCON           : round constants, RCON[i] used by round i (1..10),
//                    zero elsewhere so any 4-bit index is safe.
//   SBOX           : forward AES S-box.
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef logic [3:0][3:0][7:0] aes_block_t;
    typedef logic [31:0]          aes_word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_REV  = 2'd2
    } aes_kx_state_t;

    // Entry 0 is the rightmost element; entries 11..15 are padding.
    localparam logic [15:0][7:0] RCON = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
        8'h00
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Extract column c as a word; row 0 is the most significant byte.
    function automatic aes_word_t get_word(input aes_block_t b, input logic [1:0] c);
        return {b[0][c], b[1][c], b[2][c], b[3][c]};
    endfunction

    // Assemble a block from four words (w0 is column 0).
    function automatic aes_block_t put_words(input aes_word_t w0, input aes_word_t w1,
                                             input aes_word_t w2, input aes_word_t w3);
        aes_block_t b;
        for (int r = 0; r < 4; r++) begin
            b[r][0] = w0[31-8*r -: 8];
            b[r][1] = w1[31-8*r -: 8];
            b[r][2] = w2[31-8*r -: 8];
            b[r][3] = w3[31-8*r -: 8];
        end
        return b;
    endfunction

    // Byte r takes old byte (r+1) mod 4, byte 0 being the MSB.
    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// ---------------------------------------------------------------------------
// aes_sub_word
// Purely combinational SubWord: four parallel S-box lookups.
//   word_i : input word
//   word_o : each byte of word_i replaced by SBOX[byte]
// ---------------------------------------------------------------------------
module aes_sub_word
    import aes_pkg::*;
(
    input  aes_word_t word_i,
    output aes_word_t word_o
);

    always_comb begin
        word_o = '0;
        for (int i = 0; i < 4; i++) begin
            word_o[8*i +: 8] = SBOX[word_i[8*i +: 8]];
        end
    end

endmodule

// File: rtl/aes_inv_key_expander.sv
// ---------------------------------------------------------------------------
// aes_inv_key_expander
// Reverse-order AES-128 round-key generator for the decrypt datapath.
// Captures the cipher key on a rising edge of decrypt_en, walks the key
// schedule forward to round 10 (one round per cycle), then presents round
// keys 10 down to 0, stepping back one round per accepted key_next. Only a
// single 128-bit working key is held.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   cipher_key : cipher key, [row][col] bytes, sampled on the start edge
//   decrypt_en : rising edge starts a run; low aborts a run
//   key_next   : advance to the next-lower round key (only while key_rdy)
//   key_rdy    : round_key / round_idx valid
//   round_idx  : round number of the presented key
//   round_key  : current round key, same layout as cipher_key
//   busy       : high during forward expansion and reverse delivery
// ---------------------------------------------------------------------------
module aes_inv_key_expander
    import aes_pkg::*;
#(
    parameter int KEY_WIDTH = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  aes_block_t cipher_key,
    input  logic       decrypt_en,
    input  logic       key_next,
    output logic       key_rdy,
    output logic [3:0] round_idx,
    output aes_block_t round_key,
    output logic       busy
);

    generate
        if (KEY_WIDTH != 128) begin : g_bad_key_width
            $error("aes_inv_key_expander: only KEY_WIDTH = 128 is supported");
        end
    endgenerate

    aes_kx_state_t state_q;
    aes_block_t    key_q;
    logic [3:0]    round_cnt_q;
    logic          en_q;
    logic          key_rdy_q;
    logic          busy_q;

    // Working-key words. In FWD these are w0..w3 of round round_cnt; in REV
    // the same register holds w4..w7 of the round being presented.
    aes_word_t  k0, k1, k2, k3;
    aes_word_t  sub_in, sub_out, temp;
    logic [3:0] rcon_idx;
    aes_word_t  n0, n1, n2, n3;
    aes_word_t  p0, p1, p2, p3;
    aes_block_t fwd_key_d;
    aes_block_t rev_key_d;
    logic       start;

    assign start = decrypt_en & ~en_q;

    always_comb begin
        k0 = get_word(key_q, 2'd0);
        k1 = get_word(key_q, 2'd1);
        k2 = get_word(key_q, 2'd2);
        k3 = get_word(key_q, 2'd3);

        // One shared SubWord: the forward step feeds w3, the reverse step
        // feeds the recovered previous w3 (= w7 ^ w6). Forward uses the
        // constant of the round being produced, reverse the constant of the
        // round being undone.
        if (state_q == ST_REV) begin
            sub_in   = rot_word(k3 ^ k2);
            rcon_idx = round_cnt_q;
        end else begin
            sub_in   = rot_word(k3);
            rcon_idx = 4'(round_cnt_q + 4'd1);
        end
    end

    aes_sub_word u_sub_word (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    always_comb begin
        temp = sub_out ^ {RCON[rcon_idx], 24'h000000};

        n0 = k0 ^ temp;
        n1 = n0 ^ k1;
        n2 = n1 ^ k2;
        n3 = n2 ^ k3;
        fwd_key_d = put_words(n0, n1, n2, n3);

        p3 = k3 ^ k2;
        p2 = k2 ^ k1;
        p1 = k1 ^ k0;
        p0 = k0 ^ temp;
        rev_key_d = put_words(p0, p1, p2, p3);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            round_cnt_q <= '0;
            en_q        <= 1'b0;
            key_rdy_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            en_q <= decrypt_en;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        key_q       <= cipher_key;
                        round_cnt_q <= 4'd0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (!decrypt_en) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        key_q       <= fwd_key_d;
                        round_cnt_q <= round_cnt_q + 4'd1;
                        if (round_cnt_q == 4'd9) begin
                            key_rdy_q <= 1'b1;
                            state_q   <= ST_REV;
                        end
                    end
                end
                ST_REV: begin
                    // Abort has priority over a simultaneous key_next.
                    if (!decrypt_en) begin
                        key_rdy_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (key_next) begin
                        if (round_cnt_q != 4'd0) begin
                            key_q       <= rev_key_d;
                            round_cnt_q <= round_cnt_q - 4'd1;
                        end else begin
                            key_rdy_q <= 1'b0;
                            busy_q    <= 1'b0;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    key_rdy_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign key_rdy   = key_rdy_q;
    assign busy      = busy_q;
    assign round_idx = round_cnt_q;
    assign round_key = key_q;

endmodule

// File: tb/tb_aes_inv_key_expander.sv
module tb_aes_inv_key_expander;
    import aes_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    aes_block_t cipher_key;
    logic       decrypt_en;
    logic       key_next;
    logic       key_rdy;
    logic [3:0] round_idx;
    aes_block_t round_key;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    aes_inv_key_expander #(.KEY_WIDTH(128)) dut (
        .clk        (clk),
        .reset      (reset),
        .cipher_key (cipher_key),
        .decrypt_en (decrypt_en),
        .key_next   (key_next),
        .key_rdy    (key_rdy),
        .round_idx  (round_idx),
        .round_key  (round_key),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (GF(2^8) arithmetic) ----------------
    logic [7:0]   sb [256];
    logic [127:0] exp_rk [11];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b} >> (8 - n);
        return t[7:0];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Standard FIPS-197 expansion into 44 words; round key r = w[4r..4r+3].
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            logic [31:0] t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic aes_block_t w2b(input logic [127:0] w);
        aes_block_t b;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r][c] = w[127-32*c-8*r -: 8];
        return b;
    endfunction

    function automatic logic [127:0] b2w(input aes_block_t b);
        logic [127:0] w;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w[127-32*c-8*r -: 8] = b[r][c];
        return w;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [127:0] key;
        logic [127:0] rk10;
        logic [127:0] rk1;
        bit           stall;
    } vec_t;

    vec_t vecs [4];

    // Raise decrypt_en with the given key and wait (bounded) for key_rdy.
    // Returns the number of negedges from the start edge to key_rdy.
    task automatic start_and_wait(input logic [127:0] key, input bit noise, output int k);
        bit got = 0;
        @(negedge clk);
        cipher_key = w2b(key);
        decrypt_en = 1'b1;
        key_next   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        k = 0;
        while (k < 30 && !got) begin
            @(negedge clk);
            k++;
            if (key_rdy) got = 1;
            else if (noise) begin
                key_next   = 1'($urandom_range(0, 1));
                cipher_key = w2b(rand_key());
            end
        end
        key_next = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int k;
        int r;
        int steps;
        bit done;
        bit kn;
        expand(v.key);
        start_and_wait(v.key, 1'b1, k);
        chk({tag, " latency"}, 128'(k), 128'd11);
        if (k != 11) return;
        r = 10; steps = 0; done = 0;
        while (!done && steps < 100) begin
            steps++;
            chk({tag, " key_rdy"}, 128'(key_rdy), 128'd1);
            chk({tag, " round_idx"}, 128'(round_idx), 128'(r));
            chk({tag, $sformatf(" round_key r%0d", r)}, b2w(round_key), exp_rk[r]);
            if (r == 10) chk({tag, " table rk10"}, b2w(round_key), v.rk10);
            if (r == 1)  chk({tag, " table rk1"}, b2w(round_key), v.rk1);
            if (r == 0)  chk({tag, " rk0 == cipher key"}, b2w(round_key), v.key);
            kn = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            key_next = kn;
            @(negedge clk);
            if (kn) begin
                if (r == 0) done = 1;
                else r--;
            end
        end
        chk({tag, " sequence finished"}, 128'(done), 128'd1);
        chk({tag, " key_rdy after r0"}, 128'(key_rdy), 128'd0);
        chk({tag, " busy after r0"}, 128'(busy), 128'd0);
        key_next = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, " no restart busy"}, 128'(busy), 128'd0);
        end
        decrypt_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int  k;
        bit  seen;
        vec_t v;

        reset      = 1'b1;
        cipher_key = '0;
        decrypt_en = 1'b0;
        key_next   = 1'b0;
        build_sbox();

        vecs[0] = '{key:   128'h2b7e151628aed2a6abf7158809cf4f3c,
                    rk10:  128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                    rk1:   128'ha0fafe1788542cb123a339392a6c7605,
                    stall: 1'b0};
        for (int i = 1; i < 4; i++) begin
            vecs[i].key = rand_key();
            expand(vecs[i].key);
            vecs[i].rk10  = exp_rk[10];
            vecs[i].rk1   = exp_rk[1];
            vecs[i].stall = 1'b1;
        end

        // Reset state
        #3;
        chk("reset key_rdy", 128'(key_rdy), 128'd0);
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset round_idx", 128'(round_idx), 128'd0);
        chk("reset round_key", b2w(round_key), 128'd0);
        @(negedge clk);
        reset = 1'b0;

        // key_next while idle has no effect
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            key_next = 1'($urandom_range(0, 1));
            chk("idle key_rdy", 128'(key_rdy), 128'd0);
            chk("idle busy", 128'(busy), 128'd0);
        end
        key_next = 1'b0;

        // FIPS-197 key: single key_next pulse shows round 9, no further step
        expand(vecs[0].key);
        start_and_wait(vecs[0].key, 1'b0, k);
        chk("fips latency", 128'(k), 128'd11);
        chk("fips idx10", 128'(round_idx), 128'd10);
        chk("fips rk10", b2w(round_key), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        key_next = 1'b1;
        @(negedge clk);
        key_next = 1'b0;
        chk("fips idx9", 128'(round_idx), 128'd9);
        chk("fips rk9", b2w(round_key), 128'hac7766f319fadc2128d12941575c006e);
        @(negedge clk);
        chk("fips idx9 held", 128'(round_idx), 128'd9);
        // Abort and key_next together: abort wins, no decrement
        decrypt_en = 1'b0;
        key_next   = 1'b1;
        @(negedge clk);
        key_next = 1'b0;
        chk("abort key_rdy", 128'(key_rdy), 128'd0);
        chk("abort busy", 128'(busy), 128'd0);
        chk("abort idx kept", 128'(round_idx), 128'd9);
        chk("abort key kept", b2w(round_key), 128'hac7766f319fadc2128d12941575c006e);

        // Table-driven full sequences
        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort during FWD cycle 5, then re-raise
        @(negedge clk);
        cipher_key = w2b(vecs[0].key);
        decrypt_en = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        chk("fwd5 busy", 128'(busy), 128'd1);
        decrypt_en = 1'b0;
        @(negedge clk);
        chk("fwd abort busy", 128'(busy), 128'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (key_rdy) seen = 1;
        end
        chk("fwd abort no key_rdy", 128'(seen), 128'd0);
        run_vec(vecs[0], "rerun");

        // Reset while presenting round 6, then a new key
        expand(vecs[2].key);
        start_and_wait(vecs[2].key, 1'b0, k);
        chk("rst-run latency", 128'(k), 128'd11);
        key_next = 1'b1;
        k = 0;
        while (round_idx != 4'd6 && k < 20) begin
            @(negedge clk);
            k++;
        end
        key_next = 1'b0;
        chk("rst-run idx6", 128'(round_idx), 128'd6);
        chk("rst-run rk6", b2w(round_key), exp_rk[6]);
        #2;
        reset      = 1'b1;
        decrypt_en = 1'b0;
        #1;
        chk("async rst key_rdy", 128'(key_rdy), 128'd0);
        chk("async rst busy", 128'(busy), 128'd0);
        chk("async rst idx", 128'(round_idx), 128'd0);
        chk("async rst key", b2w(round_key), 128'd0);
        #1;
        reset = 1'b0;
        v.key = rand_key();
        expand(v.key);
        v.rk10  = exp_rk[10];
        v.rk1   = exp_rk[1];
        v.stall = 1'b1;
        run_vec(v, "post-reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
